// File: rtl/fir_cfg_master_pkg.sv
// fir_cfg_master_pkg
//   Shared definitions for the fir configuration master: the fir register
//   offsets, ap_config bit positions, cfg_err codes and the state encodings
//   of the top sequencer and the single-transaction AXI-Lite engine.
//   No ports (package).
package fir_cfg_master_pkg;

  localparam logic [11:0] REG_AP_CONFIG = 12'h000;
  localparam logic [11:0] REG_DATA_LEN  = 12'h010;
  localparam logic [11:0] REG_TAP_BASE  = 12'h020;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

  // ap_status before the first poll: the fir reports idle out of reset
  localparam logic [2:0] AP_STATUS_RESET = 3'b100;

  typedef enum logic [1:0] {
    CFG_ERR_OK      = 2'b00,
    CFG_ERR_VERIFY  = 2'b01,
    CFG_ERR_TIMEOUT = 2'b10
  } cfg_err_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TAP_WR,
    ST_TAP_RD,
    ST_LEN_WR,
    ST_START_WR,
    ST_POLL_RD,
    ST_POLL_WAIT,
    ST_FIN
  } cfg_state_e;

  typedef enum logic [1:0] {
    XIDLE,
    XWR,
    XAR,
    XR
  } xact_state_e;

  // Byte address of tap register idx
  function automatic logic [11:0] tap_addr(input logic [3:0] idx);
    return REG_TAP_BASE + {6'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/fir_axil_xact.sv
// fir_axil_xact
//   Runs exactly one AXI-Lite transaction per request. A write drives AW and
//   W together and finishes once both handshakes have happened (the channels
//   may complete in different cycles; there is no B channel). A read issues
//   AR, then raises rready, and captures rdata on the R handshake.
// Ports:
//   axis_clk, axis_rst_n          clock, async active-low reset
//   req_valid                     start a transaction (only honoured in XIDLE)
//   req_write/req_addr/req_wdata  transaction description, sampled with req_valid
//   req_done                      one-cycle pulse when the transaction has finished
//   rsp_rdata                     read data of the last completed read
//   aw*/w*/ar*/r*                 AXI-Lite initiator channels
module fir_axil_xact
  import fir_cfg_master_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   req_valid,
  input  logic                   req_write,
  input  logic [pADDR_WIDTH-1:0] req_addr,
  input  logic [pDATA_WIDTH-1:0] req_wdata,
  output logic                   req_done,
  output logic [pDATA_WIDTH-1:0] rsp_rdata,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata
);

  xact_state_e state_q, state_d;
  logic        aw_done_q, w_done_q;
  logic        aw_hs, w_hs, ar_hs, r_hs, wr_complete;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;

  // A channel counts as finished if it finished earlier or is finishing now
  assign wr_complete = (aw_done_q | aw_hs) & (w_done_q | w_hs);

  always_comb begin
    state_d = state_q;
    case (state_q)
      XIDLE:   if (req_valid) state_d = req_write ? XWR : XAR;
      XWR:     if (wr_complete) state_d = XIDLE;
      XAR:     if (ar_hs) state_d = XR;
      XR:      if (r_hs) state_d = XIDLE;
      default: state_d = XIDLE;
    endcase
  end

  // All channel outputs are registered; addresses and data are only loaded
  // from XIDLE so they stay stable for the whole transaction.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q   <= XIDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      req_done  <= 1'b0;
      rsp_rdata <= '0;
      awvalid   <= 1'b0;
      awaddr    <= '0;
      wvalid    <= 1'b0;
      wdata     <= '0;
      arvalid   <= 1'b0;
      araddr    <= '0;
      rready    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_done <= 1'b0;
      case (state_q)
        XIDLE: begin
          if (req_valid) begin
            if (req_write) begin
              awaddr    <= req_addr;
              wdata     <= req_wdata;
              awvalid   <= 1'b1;
              wvalid    <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
            end else begin
              araddr  <= req_addr;
              arvalid <= 1'b1;
            end
          end
        end
        XWR: begin
          if (aw_hs) begin
            awvalid   <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid   <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (wr_complete) req_done <= 1'b1;
        end
        XAR: begin
          // rready must wait for the AR handshake: the fir treats rready
          // with araddr==0 as the ap_done clear
          if (ar_hs) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
          end
        end
        XR: begin
          if (r_hs) begin
            rready    <= 1'b0;
            rsp_rdata <= rdata;
            req_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fir_cfg_master.sv
// fir_cfg_master
//   Programs and runs the fir block over AXI-Lite: writes every tap, can read
//   them back to verify, writes data_length, sets ap_start and polls
//   ap_config until ap_done, with a poll gap and an overall timeout.
// Ports:
//   axis_clk, axis_rst_n      clock, async active-low reset
//   cfg_start                 pulse to begin a sequence (dropped while busy)
//   cfg_verify, cfg_length    options sampled with cfg_start
//   coef_idx / coef_data      tap index request / same-cycle coefficient
//   cfg_busy, cfg_done        sequence running / end-of-sequence pulse
//   cfg_err                   00 ok, 01 verify mismatch, 10 timeout
//   ap_status                 last polled ap_config[2:0]
//   aw*/w*/ar*/r*             AXI-Lite initiator channels to the fir
module fir_cfg_master
  import fir_cfg_master_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int Tape_Num    = 11,
  parameter int pPOLL_GAP   = 8,
  parameter int pTIMEOUT    = 65535
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   cfg_start,
  input  logic                   cfg_verify,
  input  logic [9:0]             cfg_length,
  output logic [3:0]             coef_idx,
  input  logic [pDATA_WIDTH-1:0] coef_data,
  output logic                   cfg_busy,
  output logic                   cfg_done,
  output logic [1:0]             cfg_err,
  output logic [2:0]             ap_status,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata
);

  localparam int TMO_W = $clog2(pTIMEOUT + 1);
  localparam int GAP_W = (pPOLL_GAP > 1) ? $clog2(pPOLL_GAP) : 1;
  localparam logic [3:0]       LAST_TAP = 4'(Tape_Num - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(pTIMEOUT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(pPOLL_GAP - 1);

  cfg_state_e state_q, state_d;
  cfg_err_e   err_q;

  logic [3:0]             tap_i_q;
  logic                   issued_q;
  logic                   verify_q;
  logic [9:0]             length_q;
  logic [2:0]             ap_status_q;
  logic [TMO_W-1:0]       tmo_q;
  logic [GAP_W-1:0]       gap_q;

  logic                   req_valid, req_write, req_done;
  logic [pADDR_WIDTH-1:0] req_addr;
  logic [pDATA_WIDTH-1:0] req_wdata, rsp_rdata;
  logic                   tap_last, rd_mismatch, timed_out, poll_done, poll_rsp;

  assign tap_last    = (tap_i_q == LAST_TAP);
  assign rd_mismatch = (rsp_rdata != coef_data);
  assign timed_out   = (tmo_q == TMO_MAX);
  assign poll_done   = rsp_rdata[AP_DONE_BIT];
  assign poll_rsp    = (state_q == ST_POLL_RD) && req_done;

  assign coef_idx  = ((state_q == ST_TAP_WR) || (state_q == ST_TAP_RD)) ? tap_i_q : 4'd0;
  assign cfg_busy  = (state_q != ST_IDLE);
  assign cfg_done  = (state_q == ST_FIN);
  assign cfg_err   = err_q;
  assign ap_status = ap_status_q;

  // Each transaction is requested once per visit (issued_q blocks a repeat
  // while the engine is busy) and the state advances on the engine's done.
  always_comb begin
    state_d   = state_q;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    case (state_q)
      ST_IDLE: if (cfg_start) state_d = ST_TAP_WR;
      ST_TAP_WR: begin
        req_valid = !issued_q;
        req_write = 1'b1;
        req_addr  = pADDR_WIDTH'(tap_addr(tap_i_q));
        req_wdata = coef_data;
        if (req_done && tap_last) state_d = verify_q ? ST_TAP_RD : ST_LEN_WR;
      end
      ST_TAP_RD: begin
        req_valid = !issued_q;
        req_addr  = pADDR_WIDTH'(tap_addr(tap_i_q));
        if (req_done) begin
          if (rd_mismatch)   state_d = ST_FIN;
          else if (tap_last) state_d = ST_LEN_WR;
        end
      end
      ST_LEN_WR: begin
        req_valid = !issued_q;
        req_write = 1'b1;
        req_addr  = pADDR_WIDTH'(REG_DATA_LEN);
        req_wdata = pDATA_WIDTH'(length_q);
        if (req_done) state_d = ST_START_WR;
      end
      ST_START_WR: begin
        req_valid = !issued_q;
        req_write = 1'b1;
        req_addr  = pADDR_WIDTH'(REG_AP_CONFIG);
        req_wdata[AP_START_BIT] = 1'b1;
        if (req_done) state_d = ST_POLL_RD;
      end
      ST_POLL_RD: begin
        req_addr = pADDR_WIDTH'(REG_AP_CONFIG);
        // Once timed out, no new poll is launched, but one in flight is
        // allowed to finish so the bus is left clean
        if (!issued_q) begin
          if (timed_out) state_d = ST_FIN;
          else           req_valid = 1'b1;
        end else if (req_done) begin
          state_d = (poll_done || timed_out) ? ST_FIN : ST_POLL_WAIT;
        end
      end
      ST_POLL_WAIT: begin
        if (timed_out)              state_d = ST_FIN;
        else if (gap_q == GAP_LAST) state_d = ST_POLL_RD;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  // Sequencer datapath: tap index, sampled options, error code, status and
  // the poll gap / timeout counters.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      tap_i_q     <= 4'd0;
      issued_q    <= 1'b0;
      verify_q    <= 1'b0;
      length_q    <= 10'd0;
      err_q       <= CFG_ERR_OK;
      ap_status_q <= AP_STATUS_RESET;
      tmo_q       <= '0;
      gap_q       <= '0;
    end else begin
      if (req_valid)     issued_q <= 1'b1;
      else if (req_done) issued_q <= 1'b0;

      gap_q <= (state_q == ST_POLL_WAIT) ? gap_q + GAP_W'(1) : '0;

      if (poll_rsp) ap_status_q <= rsp_rdata[AP_IDLE_BIT:AP_START_BIT];

      case (state_q)
        ST_IDLE: begin
          if (cfg_start) begin
            tap_i_q  <= 4'd0;
            err_q    <= CFG_ERR_OK;
            verify_q <= cfg_verify;
            length_q <= cfg_length;
          end
        end
        ST_TAP_WR: begin
          if (req_done) tap_i_q <= tap_last ? 4'd0 : tap_i_q + 4'd1;
        end
        ST_TAP_RD: begin
          if (req_done) begin
            if (rd_mismatch) begin
              err_q   <= CFG_ERR_VERIFY;
              tap_i_q <= 4'd0;
            end else begin
              tap_i_q <= tap_last ? 4'd0 : tap_i_q + 4'd1;
            end
          end
        end
        ST_START_WR: tmo_q <= '0;
        ST_POLL_RD, ST_POLL_WAIT: begin
          if (!timed_out) tmo_q <= tmo_q + TMO_W'(1);
          // A poll that lands ap_done in the same cycle still counts as success
          if (timed_out && !(poll_rsp && poll_done)) err_q <= CFG_ERR_TIMEOUT;
        end
        default: ;
      endcase
    end
  end

  fir_axil_xact #(
    .pADDR_WIDTH(pADDR_WIDTH),
    .pDATA_WIDTH(pDATA_WIDTH)
  ) u_xact (
    .axis_clk  (axis_clk),
    .axis_rst_n(axis_rst_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_done  (req_done),
    .rsp_rdata (rsp_rdata),
    .awvalid   (awvalid),
    .awready   (awready),
    .awaddr    (awaddr),
    .wvalid    (wvalid),
    .wready    (wready),
    .wdata     (wdata),
    .arvalid   (arvalid),
    .arready   (arready),
    .araddr    (araddr),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata)
  );

endmodule
